// File: rtl/ascon_permutation_engine_if.sv
// Handshake/data bundle between the ASCON control FSM and the permutation engine.
// Optional round_o trace port is present only when ASCON_ROUND_TRACE_EN is defined.
interface ascon_permutation_engine_if;
  logic              start_i;
  logic              mode_i;
  logic              en_i;
  logic [0:4][63:0]  state_i;
  logic [0:4][63:0]  state_o;
  logic              busy_o;
  logic              valid_o;
`ifdef ASCON_ROUND_TRACE_EN
  logic [3:0]        round_o;
`endif

  modport master (
    output start_i, mode_i, en_i, state_i,
    input  state_o, busy_o, valid_o
`ifdef ASCON_ROUND_TRACE_EN
    , input round_o
`endif
  );

  modport slave (
    input  start_i, mode_i, en_i, state_i,
    output state_o, busy_o, valid_o
`ifdef ASCON_ROUND_TRACE_EN
    , output round_o
`endif
  );
endinterface

// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon permutation p^a / p^b with start/valid handshake, UNROLL rounds per clock.
// Optional macro ASCON_ROUND_TRACE_EN exposes the next round index on round_o.
module ascon_permutation_engine #(
  parameter int UNROLL   = 1,
  parameter int ROUNDS_B = 6
) (
  input  logic                        clock_i,
  input  logic                        resetb_i,
  ascon_permutation_engine_if.slave   bus
);

  localparam logic [3:0] LAST_ROUND  = 4'd12;
  localparam logic [3:0] FIRST_B     = 4'(12 - ROUNDS_B);
  localparam logic [3:0] ROUND_STEP  = 4'(UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6) ||
      (ROUNDS_B < 1) || (ROUNDS_B > 12) || ((ROUNDS_B % UNROLL) != 0)) begin : g_param_check
    $error("ascon_permutation_engine: illegal UNROLL/ROUNDS_B combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t              fsm_r, fsm_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [0:4][63:0]  state_r, state_s;
  logic              busy_r, busy_s;
  logic              valid_r, valid_s;
  logic [0:4][63:0]  rounds_s;
  logic [3:0]        cnt_step_s;

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [0:4][63:0] ascon_round(input logic [0:4][63:0] s,
                                                   input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hF - r, r};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    ascon_round[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    ascon_round[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    ascon_round[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    ascon_round[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    ascon_round[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
  endfunction

  // Chain UNROLL rounds starting at the current round index.
  always_comb begin
    rounds_s = state_r;
    for (int i = 0; i < UNROLL; i++) begin
      rounds_s = ascon_round(rounds_s, cnt_r + 4'(i));
    end
  end

  assign cnt_step_s = cnt_r + ROUND_STEP;

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    fsm_s   = fsm_r;
    cnt_s   = cnt_r;
    state_s = state_r;
    busy_s  = busy_r;
    valid_s = 1'b0;
    case (fsm_r)
      IDLE, DONE: begin
        if (bus.start_i) begin
          fsm_s   = RUN;
          state_s = bus.state_i;
          cnt_s   = bus.mode_i ? FIRST_B : 4'd0;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      RUN: begin
        if (bus.en_i) begin
          state_s = rounds_s;
          cnt_s   = cnt_step_s;
          if (cnt_step_s == LAST_ROUND) begin
            fsm_s   = DONE;
            busy_s  = 1'b0;
            valid_s = 1'b1;
          end else begin
            busy_s  = 1'b1;
          end
        end else begin
          busy_s  = 1'b1;
        end
      end
      default: begin
        fsm_s   = IDLE;
        cnt_s   = 4'd0;
        state_s = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Controller and datapath registers.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_r   <= IDLE;
      cnt_r   <= 4'd0;
      state_r <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      fsm_r   <= fsm_s;
      cnt_r   <= cnt_s;
      state_r <= state_s;
      busy_r  <= busy_s;
      valid_r <= valid_s;
    end
  end

  assign bus.state_o = state_r;
  assign bus.busy_o  = busy_r;
  assign bus.valid_o = valid_r;
`ifdef ASCON_ROUND_TRACE_EN
  assign bus.round_o = cnt_r;
`endif

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Scoreboard bench for ascon_permutation_engine: UNROLL=1/2/3 instances against a table-based model.
module tb_ascon_permutation_engine;
  typedef logic [0:4][63:0] st_t;
  typedef struct {
    st_t st;
    int  lat;
  } exp_t;

  logic clock_i  = 1'b0;
  logic resetb_i = 1'b0;
  always #5 clock_i = ~clock_i;

  ascon_permutation_engine_if if0();
  ascon_permutation_engine_if if1();
  ascon_permutation_engine_if if2();

  ascon_permutation_engine #(.UNROLL(1), .ROUNDS_B(6)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .bus(if0.slave));
  ascon_permutation_engine #(.UNROLL(2), .ROUNDS_B(6)) dut_u2 (
    .clock_i(clock_i), .resetb_i(resetb_i), .bus(if1.slave));
  ascon_permutation_engine #(.UNROLL(3), .ROUNDS_B(6)) dut_u3 (
    .clock_i(clock_i), .resetb_i(resetb_i), .bus(if2.slave));

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  exp_t q[3][$];
  int   acc[3];
  int   bcnt[3];
  logic pv[3];

  st_t s0, s1, pa0, pb0, pa1;

  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
      5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
      5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
      5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
      5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
      5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
      5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
      5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t ref_round(input st_t s, input int r);
    st_t        t;
    logic [4:0] col;
    logic [7:0] c;
    c = 8'hF0 - 8'(15 * r);
    s[2][7:0] = s[2][7:0] ^ c;
    for (int b = 0; b < 64; b++) begin
      col = sbox({s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]});
      {t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]} = col;
    end
    t[0] = t[0] ^ rot(t[0], 19) ^ rot(t[0], 28);
    t[1] = t[1] ^ rot(t[1], 61) ^ rot(t[1], 39);
    t[2] = t[2] ^ rot(t[2], 1)  ^ rot(t[2], 6);
    t[3] = t[3] ^ rot(t[3], 10) ^ rot(t[3], 17);
    t[4] = t[4] ^ rot(t[4], 7)  ^ rot(t[4], 41);
    return t;
  endfunction

  function automatic st_t ref_perm(input st_t s, input int first, input int n);
    for (int r = first; r < first + n; r++) s = ref_round(s, r);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor for one engine instance: measures latency/busy time and checks results.
  task automatic mon(input int id, input logic v, input logic b, input logic s, input st_t so);
    exp_t e;
    if (!resetb_i) begin
      pv[id]   = 1'b0;
      bcnt[id] = 0;
      acc[id]  = -1;
    end else begin
      if (v) begin
        chk($sformatf("valid_pulse_u%0d", id), {319'd0, pv[id]}, 320'd0);
        if (q[id].size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_valid_u%0d: got valid_o=1 expected no result pending", id);
        end else begin
          e = q[id].pop_front();
          chk($sformatf("result_u%0d", id), so, e.st);
          chk($sformatf("latency_u%0d", id), 320'(cyc - acc[id] - 1), 320'(e.lat));
          chk($sformatf("busy_cycles_u%0d", id), 320'(bcnt[id]), 320'(e.lat));
        end
      end
      if (b) bcnt[id]++;
      if (s && !b) begin
        acc[id]  = cyc;
        bcnt[id] = 0;
      end
      pv[id] = v;
    end
  endtask

  always @(negedge clock_i) begin
    cyc++;
    mon(0, if0.valid_o, if0.busy_o, if0.start_i, if0.state_o);
    mon(1, if1.valid_o, if1.busy_o, if1.start_i, if1.state_o);
    mon(2, if2.valid_o, if2.busy_o, if2.start_i, if2.state_o);
  end

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) return;
      @(posedge clock_i);
    end
    n_vec++;
    n_miss++;
    $display("FAIL drain_timeout: pending %0d/%0d/%0d expected 0/0/0",
             q[0].size(), q[1].size(), q[2].size());
    q[0].delete();
    q[1].delete();
    q[2].delete();
  endtask

  task automatic go(input st_t s, input logic m);
    @(posedge clock_i); #1;
    if0.start_i = 1'b1;
    if0.mode_i  = m;
    if0.state_i = s;
    @(posedge clock_i); #1;
    if0.start_i = 1'b0;
  endtask

  initial begin
    bit seen;
    s0 = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2, 64'hbe263d4d7aecaaff,
          64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};
    s1 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0000000000000000,
          64'hffffffffffffffff, 64'hdeadbeefcafef00d};
    pa0 = ref_perm(s0, 0, 12);
    pb0 = ref_perm(s0, 6, 6);
    pa1 = ref_perm(s1, 0, 12);
    if0.start_i = 1'b0; if0.mode_i = 1'b0; if0.en_i = 1'b1; if0.state_i = '0;
    if1.start_i = 1'b0; if1.mode_i = 1'b0; if1.en_i = 1'b1; if1.state_i = '0;
    if2.start_i = 1'b0; if2.mode_i = 1'b0; if2.en_i = 1'b1; if2.state_i = '0;

    repeat (3) @(posedge clock_i);
    #1;
    chk("reset_state_o", if0.state_o, 320'd0);
    chk("reset_busy_o", {319'd0, if0.busy_o}, 320'd0);
    chk("reset_valid_o", {319'd0, if0.valid_o}, 320'd0);
    @(negedge clock_i);
    resetb_i = 1'b1;

    // p^a and p^b on the UNROLL=1 instance
    q[0].push_back('{pa0, 12});
    go(s0, 1'b0);
    drain();
    q[0].push_back('{pb0, 6});
    go(s0, 1'b1);
    drain();

    // five stall cycles plus an ignored start while busy
    q[0].push_back('{pa0, 17});
    go(s0, 1'b0);
    repeat (3) @(posedge clock_i);
    #1 if0.en_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    if0.start_i = 1'b1;
    if0.mode_i  = 1'b1;
    if0.state_i = s1;
    @(posedge clock_i);
    #1 if0.start_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #1 if0.en_i = 1'b1;
    drain();

    // reset in the middle of a run, then a clean run
    go(s1, 1'b0);
    repeat (3) @(posedge clock_i);
    #2 resetb_i = 1'b0;
    #1;
    chk("abort_state_o", if0.state_o, 320'd0);
    chk("abort_busy_o", {319'd0, if0.busy_o}, 320'd0);
    chk("abort_valid_o", {319'd0, if0.valid_o}, 320'd0);
    @(negedge clock_i);
    @(negedge clock_i);
    resetb_i = 1'b1;
    repeat (15) @(posedge clock_i);
    q[0].push_back('{pa1, 12});
    go(s1, 1'b0);
    drain();

    // back-to-back: new start in the valid_o cycle
    q[0].push_back('{pa0, 12});
    go(s0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clock_i); #1;
      seen = if0.valid_o;
    end
    chk("b2b_valid_seen", {319'd0, seen}, 320'd1);
    if0.start_i = 1'b1;
    if0.mode_i  = 1'b0;
    if0.state_i = s1;
    q[0].push_back('{pa1, 12});
    @(posedge clock_i);
    #1 if0.start_i = 1'b0;
    drain();

    // UNROLL=2 and UNROLL=3 instances, p^a then p^b
    for (int m = 0; m < 2; m++) begin
      q[1].push_back('{(m == 0) ? pa0 : pb0, (m == 0) ? 6 : 3});
      q[2].push_back('{(m == 0) ? pa0 : pb0, (m == 0) ? 4 : 2});
      @(posedge clock_i); #1;
      if1.start_i = 1'b1; if1.mode_i = 1'(m); if1.state_i = s0;
      if2.start_i = 1'b1; if2.mode_i = 1'(m); if2.state_i = s0;
      @(posedge clock_i); #1;
      if1.start_i = 1'b0;
      if2.start_i = 1'b0;
      drain();
    end

    repeat (20) @(posedge clock_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
